// File: rtl/pht_gshare_table.sv
// ---------------------------------------------------------------------------
// pht_gshare_table
// Gshare pattern history table: 2**IDX_W two-bit saturating counters indexed
// by (PC word address XOR speculative global history). Predictions are
// registered one cycle after the request. Commit-side updates train counters
// and repair the GHR on a mispredict.
//
// Ports
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   busy_o               init sweep in progress; requests/updates ignored
//   pred_valid_i/pc_i    prediction request and branch PC
//   pred_valid_o         prediction valid, one cycle after the request
//   pred_taken_o         predicted direction (counter MSB)
//   pred_idx_o           table index used, carried to commit
//   pred_ghr_o           GHR before this branch's shift, carried to commit
//   upd_valid_i          resolved-branch update
//   upd_idx_i            index from pred_idx_o
//   upd_taken_i          resolved direction
//   upd_mispredict_i     direction mispredicted; repair the GHR
//   upd_ghr_i            snapshot from pred_ghr_o
//
// Build option
//   PHT_UPDATE_BYPASS_EN  forward a same-cycle update of the read index into
//                         the prediction path (default: read stored counter)
// ---------------------------------------------------------------------------
module pht_gshare_table #(
  parameter int         PC_W       = 32,
  parameter int         IDX_W      = 8,
  parameter int         GHR_W      = 8,
  parameter logic [1:0] INIT_STATE = 2'b11
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             busy_o,
  input  logic             pred_valid_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i,
  input  logic [GHR_W-1:0] upd_ghr_i
);

  localparam int DEPTH = 1 << IDX_W;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Standard 2-bit saturating counter transition.
  function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr == 2'b11) res = 2'b11;
      else              res = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) res = 2'b00;
      else              res = ctr - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]       pht_r [DEPTH];
  logic [0:0]       state_r;
  logic [IDX_W-1:0] init_cnt_r;
  logic             busy_r;
  logic [GHR_W-1:0] ghr_r;
  logic             pred_valid_r;
  logic             pred_taken_r;
  logic [IDX_W-1:0] pred_idx_r;
  logic [GHR_W-1:0] pred_ghr_r;

  logic [IDX_W-1:0] ghr_ext_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       rd_ctr_s;
  logic             rd_taken_s;
  logic             we_s;
  logic [IDX_W-1:0] wa_s;
  logic [1:0]       wd_s;
  logic             unused_bits_s;

  // PC bits outside the index field and the oldest snapshot bit never matter.
  assign unused_bits_s = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0], upd_ghr_i[GHR_W-1]};

  // Gshare index and combinational counter read (optionally update-forwarded).
  always_comb begin
    ghr_ext_s = IDX_W'(ghr_r);
    idx_s     = pred_pc_i[IDX_W+1:2] ^ ghr_ext_s;
    rd_ctr_s  = pht_r[idx_s];
`ifdef PHT_UPDATE_BYPASS_EN
    if (upd_valid_i && (upd_idx_i == idx_s)) begin
      rd_ctr_s = sat_next(pht_r[idx_s], upd_taken_i);
    end else begin
      rd_ctr_s = pht_r[idx_s];
    end
`endif
    rd_taken_s = rd_ctr_s[1];
  end

  // Single table write port: init sweep owns it in INIT, updates in READY.
  always_comb begin
    we_s = 1'b0;
    wa_s = init_cnt_r;
    wd_s = INIT_STATE;
    case (state_r)
      ST_INIT: begin
        we_s = 1'b1;
        wa_s = init_cnt_r;
        wd_s = INIT_STATE;
      end
      ST_READY: begin
        we_s = upd_valid_i;
        wa_s = upd_idx_i;
        wd_s = sat_next(pht_r[upd_idx_i], upd_taken_i);
      end
      default: begin
        we_s = 1'b0;
        wa_s = init_cnt_r;
        wd_s = INIT_STATE;
      end
    endcase
  end

  // Counter storage: no reset, contents are established by the init sweep.
  always_ff @(posedge clk) begin
    if (we_s) begin
      pht_r[wa_s] <= wd_s;
    end
  end

  // Init sweep sequencing and busy flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {IDX_W{1'b0}};
      busy_r     <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + IDX_W'(1);
          if (init_cnt_r == {IDX_W{1'b1}}) begin
            state_r <= ST_READY;
            busy_r  <= 1'b0;
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_INIT;
          init_cnt_r <= {IDX_W{1'b0}};
          busy_r     <= 1'b1;
        end
      endcase
    end
  end

  // Prediction outputs and speculative GHR; a mispredict repair wins over
  // the same-cycle speculative shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr_r        <= {GHR_W{1'b0}};
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
      pred_idx_r   <= {IDX_W{1'b0}};
      pred_ghr_r   <= {GHR_W{1'b0}};
    end else if (state_r == ST_READY) begin
      pred_valid_r <= pred_valid_i;
      if (pred_valid_i) begin
        pred_taken_r <= rd_taken_s;
        pred_idx_r   <= idx_s;
        pred_ghr_r   <= ghr_r;
      end
      if (upd_valid_i && upd_mispredict_i) begin
        ghr_r <= {upd_ghr_i[GHR_W-2:0], upd_taken_i};
      end else if (pred_valid_i) begin
        ghr_r <= {ghr_r[GHR_W-2:0], rd_taken_s};
      end
    end else begin
      pred_valid_r <= 1'b0;
    end
  end

  assign busy_o       = busy_r;
  assign pred_valid_o = pred_valid_r;
  assign pred_taken_o = pred_taken_r;
  assign pred_idx_o   = pred_idx_r;
  assign pred_ghr_o   = pred_ghr_r;

endmodule

// File: tb/tb_pht_gshare_table.sv
// Testbench for pht_gshare_table: directed scenarios plus randomized traffic,
// all checked against a behavioural table/GHR model held in integer arrays.
module tb_pht_gshare_table;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        busy;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = 32'h0;
  logic        pred_valid_q;
  logic        pred_taken_q;
  logic [7:0]  pred_idx_q;
  logic [7:0]  pred_ghr_q;
  logic        upd_valid = 1'b0;
  logic [7:0]  upd_idx = 8'h0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic [7:0]  upd_ghr = 8'h0;

`ifdef PHT_UPDATE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  pht_gshare_table dut (
    .clk              (clk),
    .resetn           (resetn),
    .busy_o           (busy),
    .pred_valid_i     (pred_valid),
    .pred_pc_i        (pred_pc),
    .pred_valid_o     (pred_valid_q),
    .pred_taken_o     (pred_taken_q),
    .pred_idx_o       (pred_idx_q),
    .pred_ghr_o       (pred_ghr_q),
    .upd_valid_i      (upd_valid),
    .upd_idx_i        (upd_idx),
    .upd_taken_i      (upd_taken),
    .upd_mispredict_i (upd_mispredict),
    .upd_ghr_i        (upd_ghr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_pht [256];
  int m_ghr;
  int m_init;
  bit m_ready;
  int e_valid, e_taken, e_idx, e_ghr, e_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    else   return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    m_ready = 1'b0; m_init = 0; m_ghr = 0;
    e_valid = 0; e_taken = 0; e_idx = 0; e_ghr = 0; e_busy = 1;
  endtask

  task automatic idle();
    pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; upd_taken = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the
  // DUT and compare every output.
  task automatic cycle();
    int idx, ctr, nghr;
    bit tk;
    if (!m_ready) begin
      m_pht[m_init] = 3;
      m_init++;
      if (m_init == 256) m_ready = 1'b1;
      e_valid = 0;
    end else begin
      idx = (int'(pred_pc >> 2) & 255) ^ m_ghr;
      ctr = m_pht[idx];
      if (BYPASS && upd_valid && (int'(upd_idx) == idx)) ctr = sat(ctr, upd_taken);
      tk = (ctr >= 2);
      nghr = m_ghr;
      if (pred_valid) begin
        e_valid = 1; e_taken = tk; e_idx = idx; e_ghr = m_ghr;
        nghr = ((m_ghr << 1) | tk) & 255;
      end else begin
        e_valid = 0;
      end
      if (upd_valid) begin
        m_pht[upd_idx] = sat(m_pht[upd_idx], upd_taken);
        if (upd_mispredict) nghr = ((int'(upd_ghr) << 1) | upd_taken) & 255;
      end
      m_ghr = nghr;
    end
    e_busy = m_ready ? 0 : 1;
    @(posedge clk); #1;
    check("busy", busy, e_busy);
    check("pred_valid", pred_valid_q, e_valid);
    check("pred_taken", pred_taken_q, e_taken);
    check("pred_idx", pred_idx_q, e_idx);
    check("pred_ghr", pred_ghr_q, e_ghr);
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    model_reset();
    check("rst_busy", busy, 1);
    check("rst_pred_valid", pred_valid_q, 0);
    check("rst_pred_taken", pred_taken_q, 0);
    check("rst_pred_idx", pred_idx_q, 0);
    check("rst_pred_ghr", pred_ghr_q, 0);
    @(posedge clk); #1;
    check("rst_hold_busy", busy, 1);
    resetn = 1'b1;
  endtask

  // Run the init sweep with random (ignored) traffic and measure busy length.
  task automatic run_sweep(input int stop_at);
    int cnt = 0;
    int busy_cnt = 0;
    while (!m_ready && m_init < stop_at && cnt < 1000) begin
      pred_valid = 1'($urandom); pred_pc = $urandom;
      upd_valid = 1'($urandom); upd_idx = 8'($urandom);
      upd_taken = 1'($urandom); upd_mispredict = 1'($urandom); upd_ghr = 8'($urandom);
      if (busy === 1'b1) busy_cnt++;
      cycle();
      cnt++;
    end
    idle();
    if (stop_at >= 256) begin
      check("sweep_busy_cycles", busy_cnt, 256);
      check("sweep_done_busy", busy, 0);
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 3;

    // Reset and full init sweep
    do_reset();
    run_sweep(256);

    // First request after init: strongly-taken counters
    pred_valid = 1'b1; pred_pc = 32'h1000;
    cycle();
    check("first_valid", pred_valid_q, 1);
    check("first_taken", pred_taken_q, 1);
    idle();

    // Repair GHR to 0, then three back-to-back requests
    upd_valid = 1'b1; upd_idx = 8'd200; upd_taken = 1'b0; upd_mispredict = 1'b1; upd_ghr = 8'h00;
    cycle();
    idle();
    pred_valid = 1'b1; pred_pc = 32'h0;
    cycle();
    check("b2b0_ghr", pred_ghr_q, 8'h00); check("b2b0_idx", pred_idx_q, 8'h00);
    pred_pc = 32'h4;
    cycle();
    check("b2b1_ghr", pred_ghr_q, 8'h01); check("b2b1_idx", pred_idx_q, 8'h00);
    pred_pc = 32'h8;
    cycle();
    check("b2b2_ghr", pred_ghr_q, 8'h03); check("b2b2_idx", pred_idx_q, 8'h01);
    idle();

    // Mispredict repair with a same-cycle request: repair wins
    upd_valid = 1'b1; upd_idx = 8'd7; upd_taken = 1'b1; upd_mispredict = 1'b1; upd_ghr = 8'h0F;
    pred_valid = 1'b1; pred_pc = 32'h40;
    cycle();
    idle();
    pred_valid = 1'b1; pred_pc = 32'h0;
    cycle();
    check("repair_ghr", pred_ghr_q, 8'h1F);
    idle();

    // Counter saturation down on idx 5, then back up
    upd_valid = 1'b1; upd_idx = 8'd5; upd_taken = 1'b0; upd_mispredict = 1'b1; upd_ghr = 8'h00;
    cycle();
    upd_mispredict = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    idle();
    pred_valid = 1'b1; pred_pc = 32'h14;
    cycle();
    check("sat_low_taken", pred_taken_q, 0);
    check("sat_low_idx", pred_idx_q, 8'd5);
    idle();
    upd_valid = 1'b1; upd_idx = 8'd5; upd_taken = 1'b1;
    cycle(); cycle();
    idle();
    pred_valid = 1'b1; pred_pc = 32'h14;
    cycle();
    check("sat_up_taken", pred_taken_q, 1);
    idle();

    // Same-index prediction and update, counter 10, not taken
    pred_valid = 1'b1; pred_pc = 32'((5 ^ m_ghr) << 2);
    upd_valid = 1'b1; upd_idx = 8'd5; upd_taken = 1'b0; upd_mispredict = 1'b0;
    cycle();
    check("same_idx_idx", pred_idx_q, 8'd5);
    check("same_idx_taken", pred_taken_q, BYPASS ? 32'd0 : 32'd1);
    idle();
    pred_valid = 1'b1; pred_pc = 32'((5 ^ m_ghr) << 2);
    cycle();
    check("same_idx_stored", pred_taken_q, 0);
    idle();

    // Randomized traffic with frequent index collisions
    for (int n = 0; n < 1500; n++) begin
      upd_valid = 1'($urandom);
      upd_idx = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      upd_taken = 1'($urandom);
      upd_mispredict = ($urandom_range(0, 3) == 0);
      upd_ghr = 8'($urandom);
      pred_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) pred_pc = 32'((int'(upd_idx) ^ m_ghr) << 2) | 32'($urandom_range(0, 3));
      else pred_pc = $urandom;
      cycle();
    end
    idle();

    // Train entries 10..13 to 00, then reset mid-sweep and verify full re-init
    for (int e = 10; e < 14; e++) begin
      upd_valid = 1'b1; upd_idx = 8'(e); upd_taken = 1'b0; upd_mispredict = 1'b0;
      for (int k = 0; k < 4; k++) cycle();
    end
    idle();
    for (int e = 10; e < 14; e++) check("trained_low", 32'(m_pht[e]), 0);
    do_reset();
    run_sweep(100);
    check("mid_sweep_busy", busy, 1);
    do_reset();
    run_sweep(256);
    for (int e = 0; e < 256; e++) begin
      pred_valid = 1'b1; pred_pc = 32'((e ^ m_ghr) << 2);
      cycle();
      check("reinit_idx", pred_idx_q, e);
      check("reinit_taken", pred_taken_q, 1);
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
